test_value_uart_tx: RTL and testbench



---
 rtl/test_value_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_test_value_uart_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/test_value_uart_tx.sv
// Streams the 16-bit test_value as "HHHH\r\n" over an 8N1 UART line.
// A new frame is started whenever the value differs from the last one sent,
// and always once after reset.
//
// state | meaning
// IDLE  | line high, waiting for a changed value (or the first frame)
// START | start bit (tx=0) of the current character
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx=1), then next character or end of frame
module test_value_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] test_value,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [2:0]    char_idx, char_idx_n;
  logic [15:0]   snapshot, snapshot_n;
  logic [15:0]   last_sent, last_sent_n;
  logic          send_first, send_first_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n, busy_n, frame_done_n;

  // ASCII for character idx of the frame: four hex digits, then CR, LF.
  function automatic logic [7:0] char_of(input logic [2:0] idx, input logic [15:0] v);
    logic [3:0] nib;
    logic [7:0] c;
    nib = 4'h0;
    case (idx)
      3'd0: nib = v[15:12];
      3'd1: nib = v[11:8];
      3'd2: nib = v[7:4];
      3'd3: nib = v[3:0];
      default: nib = 4'h0;
    endcase
    if (idx < 3'd4)
      c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    else if (idx == 3'd4)
      c = 8'h0D;
    else
      c = 8'h0A;
    return c;
  endfunction

  // State and datapath registers; reset aborts any frame and forces a resend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      char_idx   <= '0;
      snapshot   <= '0;
      last_sent  <= '0;
      send_first <= 1'b1;
      shift      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_idx    <= bit_idx_n;
      char_idx   <= char_idx_n;
      snapshot   <= snapshot_n;
      last_sent  <= last_sent_n;
      send_first <= send_first_n;
      shift      <= shift_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state and next-output logic; outputs are registered one level above.
  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt;
    bit_idx_n    = bit_idx;
    char_idx_n   = char_idx;
    snapshot_n   = snapshot;
    last_sent_n  = last_sent;
    send_first_n = send_first;
    shift_n      = shift;
    tx_n         = tx;
    busy_n       = busy;
    frame_done_n = 1'b0;

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if ((test_value != last_sent) || send_first) begin
          snapshot_n   = test_value;
          last_sent_n  = test_value;
          send_first_n = 1'b0;
          char_idx_n   = 3'd0;
          shift_n      = char_of(3'd0, test_value);
          baud_cnt_n   = '0;
          state_n      = START;
          tx_n         = 1'b0;
          busy_n       = 1'b1;
        end
      end
      START: begin
        if (baud_cnt == CNT_MAX) begin
          baud_cnt_n = '0;
          bit_idx_n  = 3'd0;
          state_n    = DATA;
          tx_n       = shift[0];
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_cnt == CNT_MAX) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_cnt == CNT_MAX) begin
          baud_cnt_n = '0;
          if (char_idx < 3'd5) begin
            char_idx_n = char_idx + 3'd1;
            shift_n    = char_of(char_idx + 3'd1, snapshot);
            state_n    = START;
            tx_n       = 1'b0;
          end else begin
            char_idx_n   = 3'd0;
            state_n      = IDLE;
            tx_n         = 1'b1;
            busy_n       = 1'b0;
            frame_done_n = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_test_value_uart_tx.sv
// Bench for test_value_uart_tx: decodes the serial line of two instances
// (4 and 5 clocks per bit) and compares against frames built from the value.
module tb_test_value_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tv4, tv5;
  logic        tx4, busy4, fd4;
  logic        tx5, busy5, fd5;

  int checks = 0;
  int failures = 0;

  test_value_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .test_value(tv4),
    .tx(tx4), .busy(busy4), .frame_done(fd4)
  );

  test_value_uart_tx #(.CLKS_PER_BIT(5)) dut5 (
    .clk(clk), .rst(rst), .test_value(tv5),
    .tx(tx5), .busy(busy5), .frame_done(fd5)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock, then settle away from the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx5 : tx4;
  endfunction
  function automatic logic cur_busy(input bit sel);
    return sel ? busy5 : busy4;
  endfunction
  function automatic logic cur_fd(input bit sel);
    return sel ? fd5 : fd4;
  endfunction

  // Reference: the text a frame must carry for value v.
  function automatic logic [7:0] exp_char(input logic [15:0] v, input int i);
    string hexd;
    int    nib;
    hexd = "0123456789ABCDEF";
    if (i == 4) return 8'h0D;
    if (i == 5) return 8'h0A;
    nib = (v >> (4 * (3 - i))) % 16;
    return hexd[nib];
  endfunction

  // Wait for a start bit, then decode and time-check one whole frame.
  task automatic rx_frame(input bit sel, input int cpb, input logic [15:0] v,
                          input int max_wait, input string name);
    bit         found;
    logic       lv, first_lv;
    logic [7:0] b;
    int         timing_err, busy_err;
    found = 0;
    timing_err = 0;
    busy_err = 0;
    for (int w = 0; w < max_wait && !found; w++) begin
      step();
      if (cur_tx(sel) === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s_start: no start bit within %0d cycles (tx=%b)", name, max_wait, cur_tx(sel));
      return;
    end
    for (int ch = 0; ch < 6; ch++) begin
      b = 8'h00;
      first_lv = 1'b0;
      for (int bt = 0; bt < 10; bt++) begin
        for (int c = 0; c < cpb; c++) begin
          if (!(ch == 0 && bt == 0 && c == 0)) step();
          lv = cur_tx(sel);
          if (c == 0) begin
            first_lv = lv;
            if (bt == 0 && lv !== 1'b0) timing_err++;
            if (bt == 9 && lv !== 1'b1) timing_err++;
            if (bt >= 1 && bt <= 8) b[bt-1] = lv;
          end else if (lv !== first_lv) begin
            timing_err++;
          end
          if (cur_busy(sel) !== 1'b1 || cur_fd(sel) !== 1'b0) busy_err++;
        end
      end
      checks++;
      if (b !== exp_char(v, ch)) begin
        failures++;
        $display("FAIL %s_char%0d: got 0x%02h expected 0x%02h", name, ch, b, exp_char(v, ch));
      end
    end
    checks++;
    if (timing_err != 0) begin
      failures++;
      $display("FAIL %s_bit_timing: %0d bad samples, expected 0", name, timing_err);
    end
    checks++;
    if (busy_err != 0) begin
      failures++;
      $display("FAIL %s_busy_in_frame: %0d cycles with busy!=1 or frame_done!=0, expected 0", name, busy_err);
    end
    step();
    checks++;
    if (cur_fd(sel) !== 1'b1 || cur_busy(sel) !== 1'b0 || cur_tx(sel) !== 1'b1) begin
      failures++;
      $display("FAIL %s_frame_end: fd=%b busy=%b tx=%b expected fd=1 busy=0 tx=1",
               name, cur_fd(sel), cur_busy(sel), cur_tx(sel));
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({tx4, busy4, fd4} !== 3'b100 || {tx5, busy5, fd5} !== 3'b100) begin
      failures++;
      $display("FAIL reset_outputs: got %b%b%b/%b%b%b expected 100/100",
               tx4, busy4, fd4, tx5, busy5, fd5);
    end
    rst = 1'b0;
  endtask

  task automatic test_release_frame();
    rx_frame(0, 4, 16'h1234, 2, "release");
  endtask

  task automatic test_hex_letters();
    tv4 = 16'hABCF;
    rx_frame(0, 4, 16'hABCF, 1, "hex");
  endtask

  task automatic test_random_values();
    logic [15:0] v;
    for (int k = 0; k < 3; k++) begin
      do v = 16'($urandom); while (v == tv4);
      tv4 = v;
      rx_frame(0, 4, v, 1, $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_no_change();
    int bad;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (tx4 !== 1'b1 || busy4 !== 1'b0 || fd4 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL no_change: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_change_during_frame();
    logic [15:0] v;
    int bad;
    do v = 16'($urandom); while (v == tv4 || v == 16'h0001 || v == 16'h0002);
    tv4 = v;
    fork
      rx_frame(0, 4, v, 1, "orig");
      begin
        repeat (60) step();
        tv4 = 16'h0001;
        repeat (40) step();
        tv4 = 16'h0002;
      end
    join
    rx_frame(0, 4, 16'h0002, 1, "latest");
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (tx4 !== 1'b1 || busy4 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL single_followup: %0d active cycles after second frame, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] v;
    bit found;
    do v = 16'($urandom); while (v == tv4 || v == 16'h0000);
    tv4 = v;
    found = 0;
    for (int w = 0; w < 4 && !found; w++) begin
      step();
      if (tx4 === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midrst_start: no start bit (tx=%b) expected 0", tx4);
    end
    repeat (15) step();
    #2;
    tv4 = 16'h0000;
    rst = 1'b1;
    #1;
    checks++;
    if (tx4 !== 1'b1 || busy4 !== 1'b0 || fd4 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: tx=%b busy=%b fd=%b expected 1 0 0", tx4, busy4, fd4);
    end
    repeat (3) step();
    rst = 1'b0;
    rx_frame(0, 4, 16'h0000, 2, "post_reset");
  endtask

  task automatic test_bit_timing_cpb5();
    logic [15:0] v;
    bit idle;
    idle = 0;
    for (int w = 0; w < 1000 && !idle; w++) begin
      step();
      if (busy5 === 1'b0) idle = 1;
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL cpb5_idle: busy=%b expected 0 within 1000 cycles", busy5);
    end
    do v = 16'($urandom); while (v == tv5);
    tv5 = v;
    rx_frame(1, 5, v, 2, "cpb5");
  endtask

  initial begin
    tv4 = 16'h1234;
    tv5 = 16'($urandom);
    test_reset();
    test_release_frame();
    test_hex_letters();
    test_random_values();
    test_no_change();
    test_change_during_frame();
    test_reset_mid_frame();
    test_bit_timing_cpb5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
